// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Even parity drives the plain XOR of the data, odd parity its inverse.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic method);
        return (^data) ^ (method == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the transmitter; read data is registered on a pop.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 wr_en_i,
    input  logic [DATA_BITS-1:0] wr_data_i,
    input  logic                 rd_en_i,
    output logic [DATA_BITS-1:0] rd_data_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]          wptr_q, wptr_d;
    logic [AW:0]          rptr_q, rptr_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] rd_data_q;
    logic                 do_wr;
    logic                 do_rd;

    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign do_wr     = wr_en_i && !full_o && !clr_i;
    assign do_rd     = rd_en_i && !empty_o && !clr_i;
    assign rd_data_o = rd_data_q;

    // Next pointer values; a clear returns both pointers to the origin.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_wr) wptr_d = wptr_q + PTR_ONE;
            if (do_rd) rptr_d = rptr_q + PTR_ONE;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            rd_data_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_rd) rd_data_q <= mem_q[rptr_q[AW-1:0]];
        end
    end

    // Storage array; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: FIFO, hold register and frame serialiser.
module uart_tx_engine
    import uart_tx_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       n_we_i,
    input  logic       n_clr_i,
    output logic       p_full_o,
    output logic       p_empty_o,
    input  logic       BaudSig_i,
    input  logic       p_ParityEnable_i,
    input  logic       ParityMethod_i,
    input  logic       p_BigEnd_i,
    input  logic       StopBits_i,
    output logic       p_busy_o,
    output logic [7:0] ByteSentNum_o,
    output logic       Tx_o
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [7:0] fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic       take;
    logic       frame_end;
    logic       next_bit;
    logic [7:0] shift_nxt;

    logic [7:0] hold_q;
    logic       hold_valid_q;
    logic       pend_q;

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [2:0] bitcnt_q;
    logic       par_en_q;
    logic       par_bit_q;
    logic       big_q;
    logic       two_stop_q;
    logic       tx_q;
    logic [7:0] count_q;

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!n_clr_i),
        .wr_en_i   (!n_we_i),
        .wr_data_i (data_i),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign pop       = !hold_valid_q && !pend_q && !fifo_empty && n_clr_i;
    assign frame_end = BaudSig_i && ((state_q == TX_STOP1 && !two_stop_q) || state_q == TX_STOP2);
    assign take      = n_clr_i && hold_valid_q && ((BaudSig_i && state_q == TX_IDLE) || frame_end);
    assign next_bit  = big_q ? shift_q[7] : shift_q[0];
    assign shift_nxt = big_q ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};

    assign Tx_o          = tx_q;
    assign p_busy_o      = (state_q != TX_IDLE);
    assign ByteSentNum_o = count_q;
    assign p_full_o      = fifo_full;
    assign p_empty_o     = fifo_empty && !hold_valid_q && !pend_q;

    // Hold register: a pop marks a pending byte, loaded one clk later from the FIFO output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pend_q       <= 1'b0;
        end else if (!n_clr_i) begin
            hold_valid_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            if (pend_q) begin
                hold_q       <= fifo_rdata;
                hold_valid_q <= 1'b1;
            end else if (take) begin
                hold_valid_q <= 1'b0;
            end
            pend_q <= pop;
        end
    end

    // Frame FSM with registered line output, config latch and sent-frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= TX_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            big_q      <= 1'b0;
            two_stop_q <= 1'b0;
            count_q    <= '0;
        end else begin
            if (take) begin
                state_q    <= TX_START;
                tx_q       <= 1'b0;
                shift_q    <= hold_q;
                par_en_q   <= p_ParityEnable_i;
                par_bit_q  <= parity_bit(hold_q, ParityMethod_i);
                big_q      <= p_BigEnd_i;
                two_stop_q <= StopBits_i;
            end else if (BaudSig_i) begin
                case (state_q)
                    TX_IDLE: begin
                        tx_q <= 1'b1;
                    end
                    TX_START: begin
                        state_q  <= TX_DATA;
                        bitcnt_q <= '0;
                        tx_q     <= next_bit;
                        shift_q  <= shift_nxt;
                    end
                    TX_DATA: begin
                        if (bitcnt_q == LAST_BIT) begin
                            if (par_en_q) begin
                                state_q <= TX_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q <= TX_STOP1;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            tx_q     <= next_bit;
                            shift_q  <= shift_nxt;
                        end
                    end
                    TX_PARITY: begin
                        state_q <= TX_STOP1;
                        tx_q    <= 1'b1;
                    end
                    TX_STOP1: begin
                        state_q <= two_stop_q ? TX_STOP2 : TX_IDLE;
                        tx_q    <= 1'b1;
                    end
                    TX_STOP2: begin
                        state_q <= TX_IDLE;
                        tx_q    <= 1'b1;
                    end
                    default: begin
                        state_q <= TX_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
            if (frame_end) count_q <= count_q + 8'd1;
        end
    end

endmodule
